result_drain: RTL
=================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: res_valid  input  1  result-ready level from the matrix core (done_matrix_mult).
REQ-004 SHALL have port: res_data  input  512  16 signed 32-bit results; C[0][0] in [511:480], row-major, C[3][3] in [31:0].
REQ-005 SHALL have port: out_valid  output  1  stream word valid.
REQ-006 SHALL have port: out_ready  input  1  downstream accept.
REQ-007 SHALL have port: out_data  output  32  result word.
REQ-008 SHALL have port: out_idx  output  4  word index, row*4+col.
REQ-009 SHALL have port: out_last  output  1  high with word 15.
REQ-010 SHALL have port: busy  output  1  high in DRAIN.
REQ-011 SHALL have port: drop_err  output  1  sticky flag, a result was lost.
REQ-012 SHALL have port: sat_flag  output  1  sticky flag, a word was saturated.

Function
REQ-013 SHALL register res_valid every cycle; capture event = res_valid & ~res_valid_q (rising edge only), since the source holds res_valid high.
REQ-014 SHALL implement FSM IDLE, DRAIN; IDLE -> DRAIN on capture event, loading res_data into a 512-bit holding register.
REQ-015 SHALL present word 0 (registered) with out_valid=1 the cycle after the capture event.
REQ-016 SHALL hold out_data, out_idx and out_last stable while out_valid & ~out_ready.
REQ-017 SHALL advance the 4-bit word counter on each out_valid & out_ready; word k = holding[511-32k -: 32].
REQ-018 SHALL on handshake of word 15 (out_last=1) return to IDLE, with out_valid=0 next cycle, unless a capture event occurs in that same cycle.
REQ-019 SHALL on a capture event coinciding with the word-15 handshake capture the new result, stay in DRAIN, and present word 0 next cycle (no bubble).
REQ-020 SHALL on any other capture event in DRAIN ignore res_data, continue the current drain, and set drop_err.
REQ-021 SHALL keep drop_err and sat_flag set until reset.
REQ-022 SHALL drive busy=1 exactly while in DRAIN.

Reset
REQ-023 SHALL on reset=0 asynchronously force: state IDLE, counter 0, res_valid_q 0, out_valid 0, out_data 0, out_idx 0, out_last 0, busy 0, drop_err 0, sat_flag 0.
REQ-024 SHALL on reset mid-drain discard the remaining words; after release, a new rising edge on res_valid is required, and a level held across reset SHALL NOT trigger a capture.

Configuration
REQ-025 SHALL, with RESULT_SAT_EN defined, clamp each word to the signed 16-bit range [-32768, 32767], sign-extend it to 32 bits, and set sat_flag when clamping occurs.
REQ-026 SHALL, without RESULT_SAT_EN, pass words unmodified and tie sat_flag to 0.

Structure
REQ-027 SHALL place the drain state enum, NUM_WORDS=16, WORD_W=32 and RES_W=512 in shared package systolic_pkg.
REQ-028 SHALL place the clamp logic in sub-module result_sat (combinational, 32-bit in, 32-bit out plus sat bit); it is instantiated only under RESULT_SAT_EN.

Verification
REQ-029 SHALL cover: res_valid 0->1 held with C[i][j]=i*4+j, out_ready=1 -> words 0..15 on 16 consecutive cycles, out_last on word 15, exactly one drain, drop_err=0.
REQ-030 SHALL cover: out_ready toggled 1,0,0,1 during drain -> out_data and out_idx held through the stall cycles, and no word skipped or repeated.
REQ-031 SHALL cover: second res_valid rising edge at word 5 -> words 6..15 come from the first result and drop_err=1.
REQ-032 SHALL cover: rising edge coincident with the word-15 handshake -> word 0 of the new result on the next cycle and drop_err=0.
REQ-033 SHALL cover: reset asserted at word 7 with res_valid held high -> all outputs 0 and no drain after release until res_valid falls and rises again.
REQ-034 SHALL cover: with RESULT_SAT_EN, C[0][0]=0x00012345 and C[0][1]=0xFFFE0000 -> 0x00007FFF and 0xFFFF8000 with sat_flag=1; without the macro, the same values pass unchanged and sat_flag=0.

Source files
------------

// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_pkg
//  Purpose  : Shared types and constants for the systolic result path.
//             Holds the drain state enum, the result geometry and a word
//             selector helper used to pick one 32-bit word out of the
//             512-bit result block (word 0 is the most significant word).
//  Revision : 1.0  initial release
// ============================================================================
package systolic_pkg;

    localparam int NUM_WORDS = 16;
    localparam int WORD_W    = 32;
    localparam int RES_W     = 512;
    localparam int IDX_W     = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    // Word k lives at res[RES_W-1-WORD_W*k -: WORD_W]; shifting left by
    // 32*k brings it to the top so a constant slice can pick it.
    function automatic logic [WORD_W-1:0] pick_word(
        input logic [RES_W-1:0] res,
        input logic [IDX_W-1:0] k
    );
        logic [RES_W-1:0] shifted;
        shifted = res << {k, 5'b0_0000};
        return shifted[RES_W-1 -: WORD_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_sat.sv
`default_nettype none
// ============================================================================
//  Module   : result_sat
//  Purpose  : Combinational clamp of a signed 32-bit result word into the
//             signed 16-bit range, sign-extended back to 32 bits.
//  Ports    : word_in  - raw signed 32-bit word
//             word_out - clamped, sign-extended word
//             sat      - high when word_in was outside [-32768, 32767]
//  Revision : 1.0  initial release
// ============================================================================
module result_sat
    import systolic_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out,
    output logic              sat
);

    localparam logic signed [WORD_W-1:0] C_MAX = 32'sd32767;
    localparam logic signed [WORD_W-1:0] C_MIN = -32'sd32768;

    always_comb begin
        word_out = word_in;
        sat      = 1'b0;
        if ($signed(word_in) > C_MAX) begin
            word_out = C_MAX;
            sat      = 1'b1;
        end else if ($signed(word_in) < C_MIN) begin
            word_out = C_MIN;
            sat      = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/result_drain.sv
`default_nettype none
// ============================================================================
//  Module   : result_drain
//  Purpose  : Captures a 4x4 block of 32-bit matrix results on the rising
//             edge of res_valid and streams it out one word per handshake
//             (row-major, C[0][0] first) on a valid/ready interface.
//  Ports    : clk, reset (async, active-low)
//             res_valid, res_data[511:0]   - result block from the core
//             out_valid, out_ready         - stream handshake
//             out_data[31:0], out_idx[3:0], out_last - stream payload
//             busy      - high while draining
//             drop_err  - sticky, a result arrived mid-drain and was lost
//             sat_flag  - sticky, a word was clamped
//  Config   : RESULT_SAT_EN - when defined, words are clamped to the signed
//             16-bit range through result_sat; otherwise passed unchanged
//             and sat_flag is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module result_drain
    import systolic_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    input  logic [RES_W-1:0]  res_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              drop_err,
    output logic              sat_flag
);

    drain_state_t      r_state;
    logic              r_res_valid_q;
    logic              r_armed;
    logic [RES_W-1:0]  r_hold;
    logic [IDX_W-1:0]  r_cnt;
    logic              r_out_valid;
    logic              r_out_last;
    logic [WORD_W-1:0] r_out_data;
    logic              r_drop_err;

    logic              w_capture;
    logic              w_handshake;
    logic              w_last_hs;
    logic              w_load;
    logic              w_advance;
    logic [IDX_W-1:0]  w_next_idx;
    logic [WORD_W-1:0] w_raw_word;
    logic [WORD_W-1:0] w_word;

    // r_armed only rises once res_valid has been seen low after reset, so a
    // level held high across reset can never look like a fresh edge.
    assign w_capture   = res_valid & ~r_res_valid_q & r_armed;
    assign w_handshake = r_out_valid & out_ready;
    assign w_last_hs   = w_handshake & r_out_last;
    // A new block is taken when idle, or back-to-back on the final handshake.
    assign w_load      = w_capture & ((r_state == ST_IDLE) | w_last_hs);
    assign w_advance   = w_handshake & ~r_out_last;
    assign w_next_idx  = w_load ? '0 : r_cnt + 1'b1;
    assign w_raw_word  = w_load ? res_data[RES_W-1 -: WORD_W]
                                : pick_word(r_hold, w_next_idx);

`ifdef RESULT_SAT_EN
    logic w_sat;
    logic r_sat_flag;

    result_sat u_sat (
        .word_in  (w_raw_word),
        .word_out (w_word),
        .sat      (w_sat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_flag <= 1'b0;
        end else if (w_sat && (w_load || w_advance)) begin
            r_sat_flag <= 1'b1;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    assign w_word   = w_raw_word;
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_res_valid_q <= 1'b0;
            r_armed       <= 1'b0;
            r_hold        <= '0;
            r_cnt         <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
            r_out_data    <= '0;
            r_drop_err    <= 1'b0;
        end else begin
            r_res_valid_q <= res_valid;
            if (!res_valid) begin
                r_armed <= 1'b1;
            end
            // Any capture that cannot be loaded lands in the middle of a drain.
            if (w_capture && !w_load) begin
                r_drop_err <= 1'b1;
            end

            if (w_load || w_advance) begin
                r_cnt       <= w_next_idx;
                r_out_data  <= w_word;
                r_out_last  <= (w_next_idx == IDX_W'(NUM_WORDS - 1));
                r_out_valid <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_hold  <= res_data;
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_load) begin
                        r_hold <= res_data;
                    end else if (w_last_hs) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_idx   = r_cnt;
    assign out_last  = r_out_last;
    assign busy      = (r_state == ST_DRAIN);
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire
